// File: rtl/gpu_ctrl_pkg.sv
// Shared types and encodings for the Filter-GPU pipeline run/hazard controller.
package gpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/pipeline_controller_if.sv
// Hazard-side bundle between the 5-stage datapath and its run/hazard controller.
interface pipeline_controller_if #(
  parameter int REG_AW = 4
);
  // Handshake: a Mem-stage access (MemtoRegM|MemWriteM) is outstanding until
  // MemReadyM is seen high; while it is low the whole pipeline holds its contents.
  logic              HaltD;
  logic              MemReadyM;
  logic [REG_AW-1:0] ra1D, ra2D, ra1E, ra2E;
  logic [REG_AW-1:0] WA3E, WA3M, WA3W;
  logic              MemtoRegE, MemtoRegM, MemWriteM;
  logic              RegWriteM, RegWriteW;
  logic              EN1, EN2, CLR2;
  logic              enE, enM, enW;
  logic [1:0]        ForwardAE, ForwardBE;

  modport master (
    output HaltD, MemReadyM, ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W,
           MemtoRegE, MemtoRegM, MemWriteM, RegWriteM, RegWriteW,
    input  EN1, EN2, CLR2, enE, enM, enW, ForwardAE, ForwardBE
  );

  modport slave (
    input  HaltD, MemReadyM, ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W,
           MemtoRegE, MemtoRegM, MemWriteM, RegWriteM, RegWriteW,
    output EN1, EN2, CLR2, enE, enM, enW, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/forward_unit.sv
// Combinational operand-forwarding selects for the Execute stage; the Mem result is newer than WriteBack.
module forward_unit
  import gpu_ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] ra1E,
  input  logic [REG_AW-1:0] ra2E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
);

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (RegWriteM && (WA3M == ra1E))      ForwardAE = FWD_M;
    else if (RegWriteW && (WA3W == ra1E)) ForwardAE = FWD_W;
    if (RegWriteM && (WA3M == ra2E))      ForwardBE = FWD_M;
    else if (RegWriteW && (WA3W == ra2E)) ForwardBE = FWD_W;
  end

endmodule

// File: rtl/pipeline_controller.sv
// Kernel run sequencer (start/halt/drain/done) with stall, flush and buffer-enable generation.
module pipeline_controller
  import gpu_ctrl_pkg::*;
#(
  parameter int REG_AW       = 4,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  pipeline_controller_if.slave hz,
  output logic             pc_clr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output state_t           dbg_state
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);

  state_t             state, state_n;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               active, accept, mem_stall, lduse, timeout, drain_last;

  forward_unit #(.REG_AW(REG_AW)) u_fwd (
    .ra1E      (hz.ra1E),
    .ra2E      (hz.ra2E),
    .WA3M      (hz.WA3M),
    .WA3W      (hz.WA3W),
    .RegWriteM (hz.RegWriteM),
    .RegWriteW (hz.RegWriteW),
    .ForwardAE (hz.ForwardAE),
    .ForwardBE (hz.ForwardBE)
  );

  assign active     = (state == RUN) || (state == DRAIN);
  assign accept     = start && !active;
  assign mem_stall  = active && (hz.MemtoRegM || hz.MemWriteM) && !hz.MemReadyM;
  assign timeout    = mem_stall && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  // A halt in Decode outranks a load-use bubble; both yield to a memory freeze.
  assign lduse      = (state == RUN) && !mem_stall && !hz.HaltD && hz.MemtoRegE &&
                      ((hz.WA3E == hz.ra1D) || (hz.WA3E == hz.ra2D));
  assign drain_last = (state == DRAIN) && !mem_stall && (drain_cnt == DRAIN_W'(1));
  assign dbg_state  = state;

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    hz.EN1  = 1'b0;
    hz.EN2  = 1'b0;
    hz.CLR2 = 1'b1;
    hz.enE  = 1'b1;
    hz.enM  = 1'b1;
    hz.enW  = 1'b1;
    if (mem_stall) begin
      hz.CLR2 = 1'b0;
      hz.enE  = 1'b0;
      hz.enM  = 1'b0;
      hz.enW  = 1'b0;
    end
    case (state)
      IDLE, ERROR: if (accept) state_n = RUN;
      DONE:        state_n = accept ? RUN : IDLE;
      RUN: begin
        if (timeout) state_n = ERROR;
        else if (!mem_stall && hz.HaltD) state_n = DRAIN;
        else if (!mem_stall && !lduse) begin
          hz.EN1  = 1'b1;
          hz.EN2  = 1'b1;
          hz.CLR2 = 1'b0;
        end
      end
      DRAIN: begin
        if (timeout)         state_n = ERROR;
        else if (drain_last) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_clr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      drain_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      pc_clr <= accept;
      busy   <= (state_n == RUN) || (state_n == DRAIN);
      done   <= drain_last;

      if (accept)       err <= 1'b0;
      else if (timeout) err <= 1'b1;

      if (mem_stall && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                       wait_cnt <= '0;

      if ((state == RUN) && (state_n == DRAIN))
        drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
      else if ((state == DRAIN) && !mem_stall && (drain_cnt != '0))
        drain_cnt <= drain_cnt - 1'b1;

      // Counters saturate so a runaway kernel never wraps back to small values.
      if (accept) begin
        cycle_cnt <= '0;
        stall_cnt <= '0;
      end else begin
        if (active && (cycle_cnt != '1))
          cycle_cnt <= cycle_cnt + 1'b1;
        if ((mem_stall || lduse) && (stall_cnt != '1))
          stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
